// File: rtl/sram_resp.sv
// ----------------------------------------------------------------------------
// sram_resp
//
// Responder for the MEM-stage data-memory request interface. Each request that
// falls inside the served byte window is executed as a multi-cycle access on
// an asynchronous 32-bit SRAM. A request moves through these phases:
// IDLE -> SETUP (1 cycle) -> STROBE (WAIT_CYCLES cycles) -> DONE (1 cycle).
// busy_o stalls the pipeline from the cycle the request appears until STROBE
// ends.
//
// The request bus is big-endian by lane: sel[3] / data[31:24] is byte offset 0.
// The SRAM is little-endian: be_n[0] / dq[7:0] is byte offset 0. Bytes are
// reversed in both directions.
//
// Optional feature, macro SRAM_RD_BUF_EN:
//   This adds a one-entry read buffer holding the word address and data of
//   the last completed read. A repeated read of that word is served from the
//   buffer with no stall. A write to that word invalidates the buffer.
//   When the macro is undefined, every read performs a full SRAM access.
//
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   req_ce_i         request valid
//   req_we_i         1 = write, 0 = read
//   req_addr_i[31:0] byte address
//   req_sel_i[3:0]   byte lanes (sel[3] = offset 0 = data[31:24])
//   req_wdata_i      write data, request lane layout
//   rdata_o          read data, request lane layout
//   busy_o           stall request to the pipeline (combinational)
//   sram_addr_o      SRAM word address (AW bits)
//   sram_dq_i/_o     SRAM data in / out, SRAM lane layout
//   sram_dq_oe_o     drive enable for sram_dq_o
//   sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_be_n_o[3:0]  active-low strobes
// ----------------------------------------------------------------------------
module sram_resp #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          AW          = 20,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_ce_i,
  input  logic          req_we_i,
  input  logic [31:0]   req_addr_i,
  input  logic [3:0]    req_sel_i,
  input  logic [31:0]   req_wdata_i,
  output logic [31:0]   rdata_o,
  output logic          busy_o,
  output logic [AW-1:0] sram_addr_o,
  input  logic [31:0]   sram_dq_i,
  output logic [31:0]   sram_dq_o,
  output logic          sram_dq_oe_o,
  output logic          sram_ce_n_o,
  output logic          sram_oe_n_o,
  output logic          sram_we_n_o,
  output logic [3:0]    sram_be_n_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_STROBE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam int            CW     = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(WAIT_CYCLES - 1);
  // The limit is computed in 33 bits so that a window ending at 4 GiB does not wrap.
  localparam logic [32:0]   LIMIT  = {1'b0, BASE_ADDR} + (33'd1 << (AW + 2));

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_we;
  logic [31:0]   r_rdata;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_dq_o;
  logic          r_dq_oe;
  logic          r_ce_n;
  logic          r_oe_n;
  logic          r_we_n;
  logic [3:0]    r_be_n;

  logic          w_hit;
  logic [AW-1:0] w_word;
  logic          w_buf_hit;
  logic          w_start;
  logic          w_rd_done;
  logic [31:0]   w_wd_swz;
  logic [31:0]   w_rd_swz;
  logic [3:0]    w_be_n;

  assign w_hit  = req_ce_i && (req_addr_i >= BASE_ADDR) && ({1'b0, req_addr_i} < LIMIT);
  assign w_word = AW'((req_addr_i - BASE_ADDR) >> 2);

  // Byte reversal between the big-endian request lanes and the little-endian SRAM.
  assign w_wd_swz = {req_wdata_i[7:0], req_wdata_i[15:8], req_wdata_i[23:16], req_wdata_i[31:24]};
  assign w_rd_swz = {sram_dq_i[7:0], sram_dq_i[15:8], sram_dq_i[23:16], sram_dq_i[31:24]};
  assign w_be_n   = ~{req_sel_i[0], req_sel_i[1], req_sel_i[2], req_sel_i[3]};

  assign w_start   = (r_state == S_IDLE) && w_hit && !w_buf_hit;
  assign w_rd_done = (r_state == S_STROBE) && (r_cnt == '0) && !r_we;
  assign busy_o    = w_start || (r_state == S_SETUP) || (r_state == S_STROBE);

  assign sram_addr_o  = r_addr;
  assign sram_dq_o    = r_dq_o;
  assign sram_dq_oe_o = r_dq_oe;
  assign sram_ce_n_o  = r_ce_n;
  assign sram_oe_n_o  = r_oe_n;
  assign sram_we_n_o  = r_we_n;
  assign sram_be_n_o  = r_be_n;

`ifdef SRAM_RD_BUF_EN
  logic          r_buf_v;
  logic [AW-1:0] r_buf_word;
  logic [31:0]   r_buf_data;

  assign w_buf_hit = (r_state == S_IDLE) && w_hit && !req_we_i && r_buf_v &&
                     (r_buf_word == w_word);
  assign rdata_o   = w_buf_hit ? r_buf_data : r_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf_v <= 1'b0;
    end else if (w_start && req_we_i && (r_buf_word == w_word)) begin
      r_buf_v <= 1'b0;
    end else if (w_rd_done) begin
      r_buf_v <= 1'b1;
    end
  end

  // NOTE: only the valid bit needs a reset; the address and data are never
  // used while the valid bit is clear, so they are left as plain storage.
  always_ff @(posedge clk) begin
    if (w_rd_done) begin
      r_buf_word <= r_addr;
      r_buf_data <= w_rd_swz;
    end
  end
`else
  assign w_buf_hit = 1'b0;
  assign rdata_o   = r_rdata;
`endif

  // NOTE: every register in this block is assigned with <=. This makes all
  // next-state values come from the pre-edge state, whatever the statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_rdata <= '0;
      r_addr  <= '0;
      r_dq_o  <= '0;
      r_dq_oe <= 1'b0;
      r_ce_n  <= 1'b1;
      r_oe_n  <= 1'b1;
      r_we_n  <= 1'b1;
      r_be_n  <= 4'hF;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            // Latch the request. The pipeline may change its inputs from now on.
            r_state <= S_SETUP;
            r_we    <= req_we_i;
            r_addr  <= w_word;
            r_be_n  <= w_be_n;
            r_dq_o  <= w_wd_swz;
            r_dq_oe <= req_we_i;
            r_ce_n  <= 1'b0;
            r_oe_n  <= req_we_i;
            r_we_n  <= 1'b1;
          end
        end
        S_SETUP: begin
          r_state <= S_STROBE;
          r_cnt   <= C_LAST;
          r_we_n  <= !r_we;
        end
        S_STROBE: begin
          if (r_cnt == '0) begin
            r_state <= S_DONE;
            r_we_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            if (!r_we) r_rdata <= w_rd_swz;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: begin
          // DONE: WE has already risen. CE and the write data are held for one
          // more cycle so the data stays valid after the strobe.
          r_state <= S_IDLE;
          r_ce_n  <= 1'b1;
          r_dq_oe <= 1'b0;
          r_be_n  <= 4'hF;
        end
      endcase
    end
  end

endmodule
